// File: rtl/huffman_pkg.sv
// -----------------------------------------------------------------------------
// huffman_pkg
// Shared types and helpers for the parametrised Huffman code builder.
//   state_e    : controller states READ / FIND / MERGE / OUT
//   weight_w() : node weight width; wide enough that merged sums never overflow
//   slice_lsb(): LSB position of symbol k (1-based) inside a flat output vector
//   cfg_legal(): NUM_SYM / CODE_W legality check, evaluated at elaboration
// -----------------------------------------------------------------------------
package huffman_pkg;

  typedef enum logic [1:0] {
    READ  = 2'd0,
    FIND  = 2'd1,
    MERGE = 2'd2,
    OUT   = 2'd3
  } state_e;

  // The sum of all NUM_SYM counters fits in CNT_W + clog2(NUM_SYM) bits.
  function automatic int weight_w(input int num_sym, input int cnt_w);
    return cnt_w + $clog2(num_sym);
  endfunction

  // Symbol k (1..NUM_SYM) occupies [(k-1)*w +: w] of every flat vector.
  function automatic int slice_lsb(input int k, input int w);
    return (k - 1) * w;
  endfunction

  // A code can be at most NUM_SYM-1 bits long, so CODE_W must cover that.
  function automatic bit cfg_legal(input int num_sym, input int code_w);
    return (num_sym >= 2) && (num_sym <= 8) && (code_w >= num_sym - 1);
  endfunction

endpackage

// File: rtl/huffman_min2_scan.sv
// -----------------------------------------------------------------------------
// huffman_min2_scan
// Sequential smallest / second-smallest tracker. One slot is presented per
// cycle in ascending index order; only strictly smaller weights displace a
// tracked entry, so ties resolve to the lower slot index.
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   scan_i                a slot is presented this cycle
//   first_i               presented slot is the first of a new scan
//   idx_i, weight_i       slot index and weight
//   active_i              slot holds a live node (inactive slots are skipped)
//   min1_idx_o/min2_idx_o index of smallest / second-smallest active slot
// -----------------------------------------------------------------------------
module huffman_min2_scan #(
  parameter int IDX_W = 3,
  parameter int WW    = 11
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             scan_i,
  input  logic             first_i,
  input  logic [IDX_W-1:0] idx_i,
  input  logic [WW-1:0]    weight_i,
  input  logic             active_i,
  output logic [IDX_W-1:0] min1_idx_o,
  output logic [IDX_W-1:0] min2_idx_o
);

  logic [IDX_W-1:0] min1_idx_q, min1_idx_d, min2_idx_q, min2_idx_d;
  logic [WW-1:0]    min1_w_q, min1_w_d, min2_w_q, min2_w_d;
  logic             min1_vld_q, min1_vld_d, min2_vld_q, min2_vld_d;
  logic             v1, v2;

  // NOTE: every signal written here gets a default first, so no path leaves
  // a value unassigned and no latch is inferred.
  always_comb begin
    min1_idx_d = min1_idx_q;
    min1_w_d   = min1_w_q;
    min1_vld_d = min1_vld_q;
    min2_idx_d = min2_idx_q;
    min2_w_d   = min2_w_q;
    min2_vld_d = min2_vld_q;
    v1         = min1_vld_q & ~first_i;
    v2         = min2_vld_q & ~first_i;
    if (scan_i) begin
      min1_vld_d = v1;
      min2_vld_d = v2;
      if (active_i) begin
        if (!v1 || (weight_i < min1_w_q)) begin
          min2_idx_d = min1_idx_q;
          min2_w_d   = min1_w_q;
          min2_vld_d = v1;
          min1_idx_d = idx_i;
          min1_w_d   = weight_i;
          min1_vld_d = 1'b1;
        end else if (!v2 || (weight_i < min2_w_q)) begin
          min2_idx_d = idx_i;
          min2_w_d   = weight_i;
          min2_vld_d = 1'b1;
        end
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      min1_idx_q <= '0;
      min1_w_q   <= '0;
      min1_vld_q <= 1'b0;
      min2_idx_q <= '0;
      min2_w_q   <= '0;
      min2_vld_q <= 1'b0;
    end else begin
      min1_idx_q <= min1_idx_d;
      min1_w_q   <= min1_w_d;
      min1_vld_q <= min1_vld_d;
      min2_idx_q <= min2_idx_d;
      min2_w_q   <= min2_w_d;
      min2_vld_q <= min2_vld_d;
    end
  end

  assign min1_idx_o = min1_idx_q;
  assign min2_idx_o = min2_idx_q;

endmodule

// File: rtl/huffman_enc_param.sv
// -----------------------------------------------------------------------------
// huffman_enc_param
// Counts symbols 1..NUM_SYM over a framed grey-level stream, then builds
// Huffman codes and masks by NUM_SYM-1 rounds of min-pair merging
// (FIND: one slot per cycle, MERGE: one cycle), finishing with one OUT cycle.
// Frames may follow back-to-back without reset.
// Build option: define HUFFMAN_CNT_SAT_EN to make the per-symbol counters
// saturate at 2^CNT_W-1 instead of wrapping.
// Ports:
//   clk, reset   clock, asynchronous active-high reset
//   gray_valid   input beat valid (ignored while busy)
//   gray_data    symbol value; only 1..NUM_SYM are counted
//   frame_end    closes the current frame (sampled only in READ)
//   busy         high in FIND, MERGE and OUT
//   CNT_valid    one-cycle pulse, cnt_flat updated
//   cnt_flat     symbol k count at [(k-1)*CNT_W +: CNT_W]
//   code_valid   one-cycle pulse, hc_flat / m_flat updated
//   hc_flat      symbol k code, LSB-aligned, root bit at MSB of used field
//   m_flat       symbol k mask, (1<<len)-1
// -----------------------------------------------------------------------------
module huffman_enc_param
  import huffman_pkg::*;
#(
  parameter int NUM_SYM = 6,
  parameter int DATA_W  = 8,
  parameter int CNT_W   = 8,
  parameter int CODE_W  = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      gray_valid,
  input  logic [DATA_W-1:0]         gray_data,
  input  logic                      frame_end,
  output logic                      busy,
  output logic                      CNT_valid,
  output logic [NUM_SYM*CNT_W-1:0]  cnt_flat,
  output logic                      code_valid,
  output logic [NUM_SYM*CODE_W-1:0] hc_flat,
  output logic [NUM_SYM*CODE_W-1:0] m_flat
);

  localparam bit CFG_OK = cfg_legal(NUM_SYM, CODE_W);
  localparam int WW     = weight_w(NUM_SYM, CNT_W);
  localparam int IDX_W  = $clog2(NUM_SYM);
  localparam int LEN_W  = $clog2(CODE_W + 1);

  if (!CFG_OK) begin : g_cfg_err
    $error("huffman_enc_param: NUM_SYM must be 2..8 and CODE_W >= NUM_SYM-1");
  end

  state_e                    state_q, state_d;
  logic [IDX_W-1:0]          scan_idx_q, scan_idx_d;
  logic [IDX_W-1:0]          iter_q, iter_d;
  logic [CNT_W-1:0]          cnt_q  [NUM_SYM];
  logic [CNT_W-1:0]          cnt_d  [NUM_SYM];
  logic [WW-1:0]             w_q    [NUM_SYM];
  logic [WW-1:0]             w_d    [NUM_SYM];
  logic [NUM_SYM-1:0]        set_q  [NUM_SYM];
  logic [NUM_SYM-1:0]        set_d  [NUM_SYM];
  logic [CODE_W-1:0]         code_q [NUM_SYM];
  logic [CODE_W-1:0]         code_d [NUM_SYM];
  logic [LEN_W-1:0]          len_q  [NUM_SYM];
  logic [LEN_W-1:0]          len_d  [NUM_SYM];
  logic [NUM_SYM-1:0]        act_q, act_d;
  logic [NUM_SYM*CNT_W-1:0]  cnt_flat_q, cnt_flat_d;
  logic [NUM_SYM*CODE_W-1:0] hc_q, hc_d, m_q, m_d;
  logic                      cnt_vld_q, cnt_vld_d, code_vld_q, code_vld_d;

  logic [IDX_W-1:0]          min1_idx, min2_idx, lo_idx, hi_idx;

  huffman_min2_scan #(
    .IDX_W (IDX_W),
    .WW    (WW)
  ) u_scan (
    .clk        (clk),
    .reset      (reset),
    .scan_i     (state_q == FIND),
    .first_i    (scan_idx_q == '0),
    .idx_i      (scan_idx_q),
    .weight_i   (w_q[scan_idx_q]),
    .active_i   (act_q[scan_idx_q]),
    .min1_idx_o (min1_idx),
    .min2_idx_o (min2_idx)
  );

  // The merged node always lands in the lower of the two slots.
  assign lo_idx = (min1_idx < min2_idx) ? min1_idx : min2_idx;
  assign hi_idx = (min1_idx < min2_idx) ? min2_idx : min1_idx;

  always_comb begin
    state_d    = state_q;
    scan_idx_d = scan_idx_q;
    iter_d     = iter_q;
    cnt_d      = cnt_q;
    w_d        = w_q;
    set_d      = set_q;
    code_d     = code_q;
    len_d      = len_q;
    act_d      = act_q;
    cnt_flat_d = cnt_flat_q;
    hc_d       = hc_q;
    m_d        = m_q;
    cnt_vld_d  = 1'b0;
    code_vld_d = 1'b0;

    case (state_q)
      READ: begin
        if (gray_valid) begin
          for (int k = 0; k < NUM_SYM; k++) begin
            if (gray_data == DATA_W'(k + 1)) begin
`ifdef HUFFMAN_CNT_SAT_EN
              if (cnt_q[k] != '1) cnt_d[k] = cnt_q[k] + CNT_W'(1);
`else
              cnt_d[k] = cnt_q[k] + CNT_W'(1);
`endif
            end
          end
        end
        // A beat in the frame_end cycle is already folded into cnt_d.
        if (frame_end) begin
          for (int k = 0; k < NUM_SYM; k++) begin
            cnt_flat_d[slice_lsb(k + 1, CNT_W) +: CNT_W] = cnt_d[k];
            w_d[k]    = WW'(cnt_d[k]);
            set_d[k]  = NUM_SYM'(1) << k;
            code_d[k] = '0;
            len_d[k]  = '0;
          end
          act_d      = '1;
          cnt_vld_d  = 1'b1;
          scan_idx_d = '0;
          iter_d     = '0;
          state_d    = FIND;
        end
      end

      FIND: begin
        if (scan_idx_q == IDX_W'(NUM_SYM - 1)) begin
          scan_idx_d = '0;
          state_d    = MERGE;
        end else begin
          scan_idx_d = scan_idx_q + IDX_W'(1);
        end
      end

      MERGE: begin
        // min1 symbols take a 1 at their current length, min2 symbols a 0;
        // both groups grow by one bit toward the root.
        for (int s = 0; s < NUM_SYM; s++) begin
          if (set_q[min1_idx][s]) begin
            code_d[s] = code_q[s] | (CODE_W'(1) << len_q[s]);
            len_d[s]  = len_q[s] + LEN_W'(1);
          end
          if (set_q[min2_idx][s]) begin
            len_d[s] = len_q[s] + LEN_W'(1);
          end
        end
        w_d[lo_idx]   = w_q[min1_idx] + w_q[min2_idx];
        set_d[lo_idx] = set_q[min1_idx] | set_q[min2_idx];
        act_d[hi_idx] = 1'b0;
        iter_d        = iter_q + IDX_W'(1);
        state_d       = (iter_q == IDX_W'(NUM_SYM - 2)) ? OUT : FIND;
      end

      OUT: begin
        for (int s = 0; s < NUM_SYM; s++) begin
          hc_d[slice_lsb(s + 1, CODE_W) +: CODE_W] = code_q[s];
          m_d[slice_lsb(s + 1, CODE_W) +: CODE_W]  =
            (CODE_W'(1) << len_q[s]) - CODE_W'(1);
          cnt_d[s] = '0;
        end
        code_vld_d = 1'b1;
        state_d    = READ;
      end

      default: state_d = READ;
    endcase
  end

  // NOTE: the node table, counters and code arrays are small register files
  // that must read as zero after reset, so every entry is explicitly reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= READ;
      scan_idx_q <= '0;
      iter_q     <= '0;
      for (int k = 0; k < NUM_SYM; k++) begin
        cnt_q[k]  <= '0;
        w_q[k]    <= '0;
        set_q[k]  <= '0;
        code_q[k] <= '0;
        len_q[k]  <= '0;
      end
      act_q      <= '0;
      cnt_flat_q <= '0;
      hc_q       <= '0;
      m_q        <= '0;
      cnt_vld_q  <= 1'b0;
      code_vld_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      scan_idx_q <= scan_idx_d;
      iter_q     <= iter_d;
      cnt_q      <= cnt_d;
      w_q        <= w_d;
      set_q      <= set_d;
      code_q     <= code_d;
      len_q      <= len_d;
      act_q      <= act_d;
      cnt_flat_q <= cnt_flat_d;
      hc_q       <= hc_d;
      m_q        <= m_d;
      cnt_vld_q  <= cnt_vld_d;
      code_vld_q <= code_vld_d;
    end
  end

  assign busy       = (state_q != READ);
  assign CNT_valid  = cnt_vld_q;
  assign cnt_flat   = cnt_flat_q;
  assign code_valid = code_vld_q;
  assign hc_flat    = hc_q;
  assign m_flat     = m_q;

endmodule

// File: tb/tb_huffman_enc_param.sv
// -----------------------------------------------------------------------------
// tb_huffman_enc_param
// Scoreboard bench for huffman_enc_param. The stimulus process drives frames
// and pushes the expected count vector, code/mask vectors and arrival cycle
// into queues; the monitor process samples on the falling edge and pops and
// compares whenever a valid pulse is due. Expected codes come from a
// behavioural Huffman model (argmin over active nodes, lower index on ties).
// -----------------------------------------------------------------------------
module tb_huffman_enc_param;

  localparam int NS  = 6;
  localparam int DW  = 8;
  localparam int CW  = 8;
  localparam int KW  = 8;
  localparam int LAT = (NS - 1) * (NS + 1) + 1;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             gray_valid = 1'b0;
  logic [DW-1:0]    gray_data = '0;
  logic             frame_end = 1'b0;
  logic             busy, CNT_valid, code_valid;
  logic [NS*CW-1:0] cnt_flat;
  logic [NS*KW-1:0] hc_flat, m_flat;

  huffman_enc_param #(
    .NUM_SYM (NS),
    .DATA_W  (DW),
    .CNT_W   (CW),
    .CODE_W  (KW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .gray_valid (gray_valid),
    .gray_data  (gray_data),
    .frame_end  (frame_end),
    .busy       (busy),
    .CNT_valid  (CNT_valid),
    .cnt_flat   (cnt_flat),
    .code_valid (code_valid),
    .hc_flat    (hc_flat),
    .m_flat     (m_flat)
  );

  always #5 clk = ~clk;

  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    longint      cyc;
    logic [63:0] a;
    logic [63:0] b;
  } exp_t;

  exp_t   cnt_sb[$];
  exp_t   code_sb[$];
  int     n_vec = 0;
  int     n_bad = 0;
  longint busy_lo = 1, busy_hi = 0;
  bit     zero_chk = 1'b0, end_chk = 1'b0;
  int     beats[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // ---------------- behavioural Huffman model ----------------
  int mw[NS], mset[NS], mcode[NS], mlen[NS];
  bit mact[NS];

  function automatic int pick_min(input int excl);
    int best = -1;
    for (int i = 0; i < NS; i++)
      if (mact[i] && i != excl && (best < 0 || mw[i] < mw[best])) best = i;
    return best;
  endfunction

  task automatic model(input int ec[NS], output logic [63:0] hc, output logic [63:0] m);
    int a, b, lo, hi;
    for (int i = 0; i < NS; i++) begin
      mw[i] = ec[i]; mset[i] = 1 << i; mact[i] = 1'b1; mcode[i] = 0; mlen[i] = 0;
    end
    repeat (NS - 1) begin
      a = pick_min(-1);
      b = pick_min(a);
      for (int s = 0; s < NS; s++) begin
        if ((mset[a] >> s) & 1) begin mcode[s] |= (1 << mlen[s]); mlen[s]++; end
        if ((mset[b] >> s) & 1) mlen[s]++;
      end
      lo = (a < b) ? a : b;
      hi = (a < b) ? b : a;
      mw[lo] = mw[a] + mw[b];
      mset[lo] = mset[a] | mset[b];
      mact[hi] = 1'b0;
    end
    hc = '0;
    m  = '0;
    for (int s = 0; s < NS; s++) begin
      hc[s*KW +: KW] = KW'(mcode[s]);
      m[s*KW +: KW]  = KW'((1 << mlen[s]) - 1);
    end
  endtask

  // ---------------- monitor ----------------
  bit   cnt_due, code_due;
  exp_t mon_e;

  always @(negedge clk) begin
    if (zero_chk) begin
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_cnt_valid", 64'(CNT_valid), 64'd0);
      check("rst_code_valid", 64'(code_valid), 64'd0);
      check("rst_cnt_flat", 64'(cnt_flat), 64'd0);
      check("rst_hc_flat", 64'(hc_flat), 64'd0);
      check("rst_m_flat", 64'(m_flat), 64'd0);
    end
    if (end_chk) check("sb_drained", 64'(cnt_sb.size() + code_sb.size()), 64'd0);
    if (!reset) begin
      check("busy", 64'(busy), 64'(cyc >= busy_lo && cyc <= busy_hi));
      cnt_due = (cnt_sb.size() > 0) && (cnt_sb[0].cyc == cyc);
      check("CNT_valid", 64'(CNT_valid), 64'(cnt_due));
      if (cnt_due) begin
        mon_e = cnt_sb.pop_front();
        if (CNT_valid) check("cnt_flat", 64'(cnt_flat), mon_e.a);
      end
      code_due = (code_sb.size() > 0) && (code_sb[0].cyc == cyc);
      check("code_valid", 64'(code_valid), 64'(code_due));
      if (code_due) begin
        mon_e = code_sb.pop_front();
        if (code_valid) begin
          check("hc_flat", 64'(hc_flat), mon_e.a);
          check("m_flat", 64'(m_flat), mon_e.b);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      gray_valid = 1'b0; frame_end = 1'b0;
    end
  endtask

  // Drives the beats queue as one frame. fe_last: frame_end rides on the last
  // beat; junk: random beats/frame_end while busy; use_const: expect the
  // known reference codes; abort>0: reset that many edges into the build.
  task automatic run_frame(input bit fe_last, input bit junk, input bit use_const, input int abort);
    int          n[NS];
    int          ec[NS];
    int          v;
    longint      fe_cyc;
    logic [63:0] cf, hc, m;
    foreach (n[i]) n[i] = 0;
    for (int i = 0; i < beats.size(); i++) begin
      @(posedge clk); #1;
      v = beats[i];
      if (v < 0) begin
        gray_valid = 1'b0; gray_data = 8'd1;
      end else begin
        gray_valid = 1'b1; gray_data = v[DW-1:0];
        if (v >= 1 && v <= NS) n[v-1]++;
      end
      frame_end = fe_last && (i == beats.size() - 1);
    end
    if (!fe_last || beats.size() == 0) begin
      @(posedge clk); #1;
      gray_valid = 1'b0; frame_end = 1'b1;
    end
    fe_cyc = cyc + 1;
    cf = '0;
    for (int k = 0; k < NS; k++) begin
`ifdef HUFFMAN_CNT_SAT_EN
      ec[k] = (n[k] > (1 << CW) - 1) ? (1 << CW) - 1 : n[k];
`else
      ec[k] = n[k] % (1 << CW);
`endif
      cf[k*CW +: CW] = CW'(ec[k]);
    end
    if (use_const) begin
      hc = {16'h0, 8'h05, 8'h04, 8'h03, 8'h03, 8'h02, 8'h00};
      m  = {16'h0, 8'h0F, 8'h0F, 8'h07, 8'h03, 8'h03, 8'h03};
    end else begin
      model(ec, hc, m);
    end
    cnt_sb.push_back('{cyc: fe_cyc, a: cf, b: 64'd0});
    if (abort == 0) code_sb.push_back('{cyc: fe_cyc + LAT, a: hc, b: m});
    busy_lo = fe_cyc;
    busy_hi = fe_cyc + LAT - 1;
    if (abort > 0) begin
      repeat (abort) begin
        @(posedge clk); #1;
        gray_valid = 1'b0; frame_end = 1'b0;
      end
      reset = 1'b1;
      busy_lo = 1; busy_hi = 0;
      zero_chk = 1'b1;
      @(posedge clk); #1;
      zero_chk = 1'b0;
      reset = 1'b0;
    end else begin
      for (int j = 0; j < LAT; j++) begin
        @(posedge clk); #1;
        if (junk) begin
          gray_valid = 1'b1;
          gray_data  = DW'($urandom_range(1, NS));
          frame_end  = 1'($urandom_range(0, 1));
        end else begin
          gray_valid = 1'b0; frame_end = 1'b0;
        end
      end
    end
  endtask

  // Reference frame: counts {10,6,4,3,2,1}, symbol 6 last.
  task automatic build_base();
    int cnts[5] = '{10, 6, 4, 3, 2};
    int t, j;
    beats.delete();
    for (int s = 0; s < 5; s++) repeat (cnts[s]) beats.push_back(s + 1);
    for (int i = beats.size() - 1; i > 0; i--) begin
      j = $urandom_range(0, i);
      t = beats[i]; beats[i] = beats[j]; beats[j] = t;
    end
    beats.push_back(6);
  endtask

  task automatic build_random(input int maxlen);
    int len;
    beats.delete();
    len = $urandom_range(0, maxlen);
    repeat (len) begin
      if ($urandom_range(0, 7) == 0) beats.push_back(-1);
      else beats.push_back($urandom_range(0, NS + 3));
    end
  endtask

  initial begin
    // reset state
    repeat (3) @(posedge clk);
    #1;
    zero_chk = 1'b1;
    @(posedge clk); #1;
    zero_chk = 1'b0;
    reset = 1'b0;
    idle(2);

    // reference frame, frame_end on the final symbol-6 beat
    build_base();
    run_frame(1'b1, 1'b0, 1'b1, 0);

    // same frame interleaved with 0/7/255 and invalid beats, junk while busy
    build_base();
    beats.insert(0, 0);
    beats.insert(5, 7);
    beats.insert(9, 255);
    beats.insert(12, -1);
    beats.insert(14, 0);
    run_frame(1'b0, 1'b1, 1'b1, 0);

    // back-to-back: final beat of symbol 6 coincident with frame_end
    beats.delete();
    beats.push_back(2);
    beats.push_back(6);
    run_frame(1'b1, 1'b0, 1'b0, 0);

    // empty frame
    beats.delete();
    run_frame(1'b0, 1'b0, 1'b0, 0);

    // random frames
    for (int f = 0; f < 6; f++) begin
      build_random(40);
      run_frame(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, 0);
    end

    // counter wrap / saturation
    beats.delete();
    repeat (300) beats.push_back(1);
    run_frame(1'b1, 1'b0, 1'b0, 0);

    // reset during FIND, then a normal frame
    build_random(20);
    run_frame(1'b1, 1'b0, 1'b0, 5);
    idle(2);
    build_random(30);
    run_frame(1'b0, 1'b0, 1'b0, 0);
    idle(3);

    for (int i = 0; i < 200 && (cnt_sb.size() + code_sb.size()) > 0; i++) @(posedge clk);
    #1;
    end_chk = 1'b1;
    @(posedge clk); #1;
    end_chk = 1'b0;
    @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: bench did not reach its summary");
    $fatal(1, "timeout");
  end

endmodule
